// File: rtl/alu_master_if.sv
// Bundle between alu_master and its neighbours: client command/result port plus
// the Wishbone pipelined ALU port. The master modport is the alu_master view.
interface alu_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [8:0]  cmd_op;
  logic [17:0] cmd_al;
  logic [17:0] cmd_bl;
  logic [17:0] cmd_ar;
  logic [17:0] cmd_br;
  logic [47:0] cmd_cl;
  logic [47:0] cmd_cr;

  logic        res_valid;
  logic [47:0] res_pl;
  logic [47:0] res_pr;
  logic        res_func;
  logic        busy;
  logic        err;

  logic        alu_cycle;
  logic        alu_strobe;
  logic        alu_ack;
  logic        alu_stall;
  logic [8:0]  alu_op;
  logic [17:0] alu_al;
  logic [17:0] alu_bl;
  logic [17:0] alu_ar;
  logic [17:0] alu_br;
  logic [47:0] alu_cl;
  logic [47:0] alu_cr;
  logic [47:0] alu_pl;
  logic [47:0] alu_pr;

  modport master (
    input  cmd_valid, cmd_op, cmd_al, cmd_bl, cmd_ar, cmd_br, cmd_cl, cmd_cr,
    input  alu_ack, alu_stall, alu_pl, alu_pr,
    output cmd_ready, res_valid, res_pl, res_pr, res_func, busy, err,
    output alu_cycle, alu_strobe, alu_op, alu_al, alu_bl, alu_ar, alu_br, alu_cl, alu_cr
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_al, cmd_bl, cmd_ar, cmd_br, cmd_cl, cmd_cr,
    output alu_ack, alu_stall, alu_pl, alu_pr,
    input  cmd_ready, res_valid, res_pl, res_pr, res_func, busy, err,
    input  alu_cycle, alu_strobe, alu_op, alu_al, alu_bl, alu_ar, alu_br, alu_cl, alu_cr
  );
endinterface

// File: rtl/alu_master.sv
// Wishbone pipelined master for the ALU: pipelines DSP-mode ops, serialises
// function-mode ops, returns results in issue order and watches for lost acks.
module alu_master #(
  parameter int MAX_OUTSTANDING = 3,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input logic          clk,
  input logic          reset,
  alu_master_if.master bus
);
  localparam logic       ALU_MODE_DSP = 1'b1;
  localparam logic [2:0] MAX_O        = 3'(MAX_OUTSTANDING);
  localparam logic [9:0] WD_LAST      = 10'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DSP, S_FUNC} state_t;

  state_t                     state, state_n;
  logic [2:0]                 outst, outst_n, eff;
  logic [9:0]                 wdog, wdog_n;
  logic [MAX_OUTSTANDING-1:0] fifo, fifo_n;
  logic                       is_func, ack_hit, ack_stray, tmo;
  logic                       can_issue, strobe, accept;

  assign is_func   = bus.cmd_op[8] != ALU_MODE_DSP;
  assign ack_hit   = bus.alu_ack && (outst != 3'd0);
  assign ack_stray = bus.alu_ack && (outst == 3'd0);
  assign tmo       = (outst != 3'd0) && !bus.alu_ack && (wdog == WD_LAST);
  // Occupancy once this cycle's ack retires; lets the slot freed by an ack be reused at once.
  assign eff       = outst - {2'b00, ack_hit};

  always_comb begin
    can_issue = 1'b0;
    state_n   = state;
    case (state)
      S_IDLE:  can_issue = 1'b1;
      S_DSP:   can_issue = is_func ? (eff == 3'd0) : (eff < MAX_O);
      default: can_issue = 1'b0;
    endcase

    strobe = bus.cmd_valid && can_issue && !reset && !tmo;
    accept = strobe && !bus.alu_stall;

    if (tmo)                             state_n = S_IDLE;
    else if (accept && is_func)          state_n = S_FUNC;
    else if (accept)                     state_n = S_DSP;
    else if (ack_hit && outst == 3'd1)   state_n = S_IDLE;

    outst_n = tmo ? 3'd0 : outst + {2'b00, accept} - {2'b00, ack_hit};

    // Head of the mode FIFO sits at bit 0; a new entry lands just past the survivors.
    fifo_n = fifo;
    if (ack_hit) fifo_n = fifo >> 1;
    if (accept) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (3'(i) == eff) fifo_n[i] = is_func;
      end
    end
    if (tmo) fifo_n = '0;

    if (tmo || bus.alu_ack || !((outst != 3'd0) || accept)) wdog_n = '0;
    else                                                      wdog_n = wdog + 10'd1;
  end

  assign bus.alu_strobe = strobe;
  assign bus.cmd_ready  = accept;
  assign bus.busy       = outst != 3'd0;
  assign bus.alu_cycle  = strobe || (outst != 3'd0);
  // The slave ORs the request buses together, so they must be zero when not strobing.
  assign bus.alu_op     = strobe ? bus.cmd_op : '0;
  assign bus.alu_al     = strobe ? bus.cmd_al : '0;
  assign bus.alu_bl     = strobe ? bus.cmd_bl : '0;
  assign bus.alu_ar     = strobe ? bus.cmd_ar : '0;
  assign bus.alu_br     = strobe ? bus.cmd_br : '0;
  assign bus.alu_cl     = strobe ? bus.cmd_cl : '0;
  assign bus.alu_cr     = strobe ? bus.cmd_cr : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      outst         <= 3'd0;
      wdog          <= '0;
      fifo          <= '0;
      bus.res_valid <= 1'b0;
      bus.err       <= 1'b0;
      bus.res_func  <= 1'b0;
      bus.res_pl    <= '0;
      bus.res_pr    <= '0;
    end else begin
      state         <= state_n;
      outst         <= outst_n;
      wdog          <= wdog_n;
      fifo          <= fifo_n;
      bus.res_valid <= ack_hit;
      bus.err       <= tmo || ack_stray;
      if (ack_hit) begin
        bus.res_pl   <= bus.alu_pl;
        bus.res_pr   <= bus.alu_pr;
        bus.res_func <= fifo[0];
      end
    end
  end
endmodule

// File: tb/tb_alu_master.sv
// Bench for alu_master: slave model with a 3-cycle DSP ack pipe, an in-order
// transaction model of outstanding ops, directed scenarios and a random soak.
module tb_alu_master;
  localparam int   MAXO     = 3;
  localparam int   TO       = 24;
  localparam int   FLAT     = 20;
  localparam logic MODE_DSP = 1'b1;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  alu_master_if bus();

  alu_master #(.MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          due;
    logic [47:0] pl;
    logic [47:0] pr;
  } ack_t;

  ack_t pend[$];
  bit   q_inf[$];
  int   stall_left  = 0;
  bit   rand_stall  = 0;
  bit   drop_acks   = 0;
  int   stray_cyc   = -1;
  int   wd_fire_cyc = -1;
  int   n_acc = 0;
  int   n_res = 0;

  // Slave: answers accepted ops in order at their due cycle.
  initial begin
    bus.alu_ack = 1'b0; bus.alu_stall = 1'b0; bus.alu_pl = '0; bus.alu_pr = '0;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_al = '0; bus.cmd_bl = '0;
    bus.cmd_ar = '0; bus.cmd_br = '0; bus.cmd_cl = '0; bus.cmd_cr = '0;
  end

  always @(posedge clk) begin
    #1;
    bus.alu_ack = 1'b0;
    bus.alu_pl  = '0;
    bus.alu_pr  = '0;
    if (pend.size() != 0 && pend[0].due == cyc) begin
      bus.alu_ack = 1'b1;
      bus.alu_pl  = pend[0].pl;
      bus.alu_pr  = pend[0].pr;
      void'(pend.pop_front());
    end else if (stray_cyc == cyc) begin
      bus.alu_ack = 1'b1;
      bus.alu_pl  = {16'h0, $urandom};
      bus.alu_pr  = {16'h0, $urandom};
    end
    bus.alu_stall = (stall_left > 0) || (rand_stall && $urandom_range(0, 9) == 0);
    if (stall_left > 0) stall_left--;
  end

  // Reference model: ops in flight as an ordered list of mode bits.
  logic         has_func, exp_strobe, exp_ready, exp_rv, exp_err, exp_func, is_f, wd_now;
  logic [47:0]  exp_pl, exp_pr;
  logic [5:0]   exp_ctrl, got_ctrl;
  logic [176:0] exp_bus, got_bus;
  int           n_after;
  initial begin exp_rv = 0; exp_err = 0; exp_func = 0; exp_pl = '0; exp_pr = '0; end

  always @(negedge clk) begin
    if (reset) begin
      total++;
      if ({bus.alu_strobe, bus.cmd_ready} !== 2'b00) begin
        bad++;
        $display("FAIL reset_gate cyc=%0d got strobe/ready=%b want 00", cyc, {bus.alu_strobe, bus.cmd_ready});
      end
      q_inf.delete();
      pend.delete();
      exp_rv  = 1'b0;
      exp_err = 1'b0;
    end else begin
      has_func = 1'b0;
      foreach (q_inf[i]) if (q_inf[i]) has_func = 1'b1;
      n_after = q_inf.size() - ((bus.alu_ack && q_inf.size() != 0) ? 1 : 0);
      wd_now  = (cyc == wd_fire_cyc);
      is_f    = bus.cmd_op[8] != MODE_DSP;
      exp_strobe = bus.cmd_valid && !wd_now && !has_func && (is_f ? (n_after == 0) : (n_after < MAXO));
      exp_ready  = exp_strobe && !bus.alu_stall;

      exp_ctrl = {exp_strobe, exp_ready, exp_strobe || q_inf.size() != 0, q_inf.size() != 0, exp_rv, exp_err};
      got_ctrl = {bus.alu_strobe, bus.cmd_ready, bus.alu_cycle, bus.busy, bus.res_valid, bus.err};
      total++;
      if (got_ctrl !== exp_ctrl) begin
        bad++;
        $display("FAIL ctrl cyc=%0d strobe/ready/cycle/busy/rv/err got %b want %b", cyc, got_ctrl, exp_ctrl);
      end

      got_bus = {bus.alu_op, bus.alu_al, bus.alu_bl, bus.alu_ar, bus.alu_br, bus.alu_cl, bus.alu_cr};
      exp_bus = exp_strobe ? {bus.cmd_op, bus.cmd_al, bus.cmd_bl, bus.cmd_ar, bus.cmd_br, bus.cmd_cl, bus.cmd_cr} : '0;
      total++;
      if (got_bus !== exp_bus) begin
        bad++;
        $display("FAIL alu_bus cyc=%0d got %h want %h", cyc, got_bus, exp_bus);
      end

      if (exp_rv) begin
        total++;
        if ({bus.res_pl, bus.res_pr, bus.res_func} !== {exp_pl, exp_pr, exp_func}) begin
          bad++;
          $display("FAIL result cyc=%0d got pl=%h pr=%h func=%b want pl=%h pr=%h func=%b",
                   cyc, bus.res_pl, bus.res_pr, bus.res_func, exp_pl, exp_pr, exp_func);
        end
      end
      if (bus.res_valid) n_res++;

      total++;
      if (q_inf.size() > MAXO) begin
        bad++;
        $display("FAIL outst_limit cyc=%0d got %0d want <=%0d", cyc, q_inf.size(), MAXO);
      end

      exp_rv  = 1'b0;
      exp_err = 1'b0;
      if (bus.alu_ack) begin
        if (q_inf.size() != 0) begin
          exp_rv   = 1'b1;
          exp_func = q_inf.pop_front();
          exp_pl   = bus.alu_pl;
          exp_pr   = bus.alu_pr;
        end else begin
          exp_err = 1'b1;
        end
      end
      if (exp_ready) begin
        q_inf.push_back(is_f);
        n_acc++;
        if (!drop_acks) pend.push_back('{cyc + (is_f ? FLAT : 3), {16'h0, $urandom}, {16'h0, $urandom}});
      end
      if (wd_now) begin
        q_inf.delete();
        exp_err = 1'b1;
      end
    end
  end

  task automatic drive_cmd(input bit f);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = {f ? ~MODE_DSP : MODE_DSP, 8'($urandom)};
    bus.cmd_al    = 18'($urandom);
    bus.cmd_bl    = 18'($urandom);
    bus.cmd_ar    = 18'($urandom);
    bus.cmd_br    = 18'($urandom);
    bus.cmd_cl    = {16'($urandom), $urandom};
    bus.cmd_cr    = {16'($urandom), $urandom};
  endtask

  task automatic issue(input bit f, output int st, output int acc);
    @(posedge clk); #1;
    drive_cmd(f);
    st  = cyc;
    acc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin acc = cyc; break; end
      @(posedge clk); #1;
    end
    if (acc < 0) begin
      total++; bad++;
      $display("FAIL issue_timeout start=%0d got no cmd_ready want accept", st);
    end
  endtask

  task automatic release_cmd();
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while ((q_inf.size() != 0 || pend.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL drain got %0d ops in flight want 0", q_inf.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_cmd(1'b0);
    repeat (3) @(negedge clk);
    total++;
    if ({bus.alu_strobe, bus.cmd_ready, bus.alu_cycle} !== 3'b000) begin
      bad++;
      $display("FAIL reset_hold got strobe/ready/cycle=%b want 000", {bus.alu_strobe, bus.cmd_ready, bus.alu_cycle});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.res_valid, bus.res_pl, bus.res_pr, bus.res_func, bus.busy, bus.err, bus.alu_cycle, bus.cmd_ready} !== '0) begin
      bad++;
      $display("FAIL reset_values got rv=%b pl=%h pr=%h func=%b busy=%b err=%b cycle=%b want all 0",
               bus.res_valid, bus.res_pl, bus.res_pr, bus.res_func, bus.busy, bus.err, bus.alu_cycle);
    end
  endtask

  task automatic test_back_to_back();
    int st, a0, a1, a2;
    int rc[$];
    issue(1'b0, st, a0);
    issue(1'b0, st, a1);
    issue(1'b0, st, a2);
    release_cmd();
    total++;
    if (a1 != a0 + 1 || a2 != a0 + 2) begin
      bad++;
      $display("FAIL b2b_accept got %0d,%0d,%0d want consecutive", a0, a1, a2);
    end
    while (cyc < a0 + 8) begin
      @(negedge clk);
      if (bus.res_valid) rc.push_back(cyc);
      if (cyc == a0 + 5) begin
        total++;
        if (bus.alu_cycle !== 1'b1) begin bad++; $display("FAIL b2b_cycle_hi got %b want 1", bus.alu_cycle); end
      end
      if (cyc == a0 + 6) begin
        total++;
        if ({bus.alu_cycle, bus.busy} !== 2'b00) begin
          bad++; $display("FAIL b2b_cycle_lo got cycle/busy=%b want 00", {bus.alu_cycle, bus.busy});
        end
      end
    end
    total++;
    if (rc.size() != 3 || rc[0] != a0 + 4 || rc[2] != a0 + 6) begin
      bad++;
      $display("FAIL b2b_results got %0d pulses first=%0d want 3 pulses at %0d..%0d",
               rc.size(), (rc.size() != 0) ? rc[0] : -1, a0 + 4, a0 + 6);
    end
    drain();
  endtask

  task automatic test_outstanding_limit();
    int st;
    int a[4];
    for (int i = 0; i < 4; i++) issue(1'b0, st, a[i]);
    release_cmd();
    total++;
    if (a[3] != a[0] + 3) begin
      bad++;
      $display("FAIL limit_fourth got accept %0d want %0d", a[3] - a[0], 3);
    end
    drain();
  endtask

  task automatic test_func_after_dsp();
    int st, a0, as, ad;
    issue(1'b0, st, a0);
    issue(1'b1, st, as);
    total++;
    if (as != a0 + 3) begin
      bad++; $display("FAIL func_issue got offset %0d want 3", as - a0);
    end
    issue(1'b0, st, ad);
    total++;
    if (ad != as + FLAT + 1) begin
      bad++; $display("FAIL func_block got offset %0d want %0d", ad - as, FLAT + 1);
    end
    total++;
    if ({bus.res_valid, bus.res_func} !== 2'b11) begin
      bad++; $display("FAIL func_result got rv/func=%b want 11", {bus.res_valid, bus.res_func});
    end
    release_cmd();
    drain();
  endtask

  task automatic test_stall();
    int st, acc, r0;
    r0 = n_res;
    stall_left = 4;
    issue(1'b0, st, acc);
    release_cmd();
    total++;
    if (acc != st + 4) begin
      bad++; $display("FAIL stall_accept got offset %0d want 4", acc - st);
    end
    drain();
    total++;
    if (n_res - r0 != 1) begin
      bad++; $display("FAIL stall_results got %0d want 1", n_res - r0);
    end
  endtask

  task automatic test_watchdog();
    int st, a, r0;
    drop_acks = 1'b1;
    issue(1'b0, st, a);
    wd_fire_cyc = a + TO - 1;
    stray_cyc   = a + TO + 7;
    r0 = n_res;
    release_cmd();
    drop_acks = 1'b0;
    while (cyc < a + TO + 9) begin
      @(negedge clk);
      if (cyc == a + TO) begin
        total++;
        if ({bus.err, bus.busy, bus.alu_cycle} !== 3'b100) begin
          bad++; $display("FAIL wdog_err got err/busy/cycle=%b want 100", {bus.err, bus.busy, bus.alu_cycle});
        end
      end
      if (cyc == a + TO + 8) begin
        total++;
        if ({bus.err, bus.res_valid} !== 2'b10) begin
          bad++; $display("FAIL stray_ack got err/rv=%b want 10", {bus.err, bus.res_valid});
        end
      end
    end
    total++;
    if (n_res != r0) begin
      bad++; $display("FAIL wdog_results got %0d want 0", n_res - r0);
    end
    drain();
  endtask

  task automatic test_reset_mid_burst();
    int st, a0, a1, a2, acc, rc;
    issue(1'b0, st, a0);
    issue(1'b0, st, a1);
    issue(1'b0, st, a2);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.res_valid, bus.res_pl, bus.res_pr, bus.res_func, bus.busy, bus.err, bus.alu_cycle, bus.cmd_ready} !== '0) begin
      bad++;
      $display("FAIL midreset_values got rv=%b pl=%h busy=%b err=%b cycle=%b want all 0",
               bus.res_valid, bus.res_pl, bus.busy, bus.err, bus.alu_cycle);
    end
    issue(1'b0, st, acc);
    release_cmd();
    rc = -1;
    for (int i = 0; i < 10 && rc < 0; i++) begin
      @(negedge clk);
      if (bus.res_valid) rc = cyc;
    end
    total++;
    if (rc != acc + 4) begin
      bad++; $display("FAIL post_reset_op got result at offset %0d want 4", rc - acc);
    end
    drain();
  endtask

  task automatic test_random();
    bit took = 1'b0;
    int a0, r0;
    a0 = n_acc;
    r0 = n_res;
    rand_stall = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (!bus.cmd_valid || took) begin
        if ($urandom_range(0, 9) < 7) drive_cmd($urandom_range(0, 99) < 15);
        else bus.cmd_valid = 1'b0;
      end
      @(negedge clk);
      took = bus.cmd_ready;
    end
    release_cmd();
    rand_stall = 1'b0;
    drain();
    total++;
    if ((n_acc - a0) != (n_res - r0) || (n_acc - a0) < 50) begin
      bad++; $display("FAIL random_count got %0d results for %0d accepts", n_res - r0, n_acc - a0);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_outstanding_limit();
    test_func_after_dsp();
    test_stall();
    test_watchdog();
    test_reset_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout at cyc=%0d", cyc);
    $fatal(1);
  end
endmodule
